// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI mode-0 master controller.
package spi_ctrl_pkg;

  localparam int DATA_W          = 8;
  localparam int DIV_W           = 8;
  localparam int CMD_CS_BIT      = 0;
  localparam int CMD_CLR_OVR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for sck: counts 0..CLK_DIV-1 while enabled, pulses tc on the last count.
module spi_clk_div
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign tc = en && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr)     div_cnt_d = '0;
    else if (tc) div_cnt_d = '0;
    else if (en) div_cnt_d = div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/spi_ctrl.sv
// SPI mode-0 master: byte sequencer behind the APB bridge strobes.
// Build option SPI_CTRL_LOOPBACK_EN: receive path samples mosi instead of miso.
module spi_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rx_valid,
  output logic              ovr,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              busy_q, busy_d, rxv_q, rxv_d, ovr_q, ovr_d;
  logic              sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic              start, tc, sample;

`ifdef SPI_CTRL_LOOPBACK_EN
  assign sample = mosi_q;
`else
  assign sample = miso;
`endif

  assign start = (state_q == IDLE) && wr && !cmd;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (busy_q),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    rxv_d   = rxv_q;
    ovr_d   = ovr_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;

    if (rd) rxv_d = 1'b0;

    // Commands only land between bytes; a mid-byte deselect would corrupt the slave.
    if (cmd && !busy_q) begin
      cs_n_d = !wdata[CMD_CS_BIT];
      if (wdata[CMD_CLR_OVR_BIT]) ovr_d = 1'b0;
    end
    if ((cmd && busy_q) || (wr && (busy_q || cmd))) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = wdata;
          mosi_d  = wdata[DATA_W-1];
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (tc) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], sample};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tc) begin
          sck_d = 1'b0;
          if (bit_q != LAST_BIT) begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_W-2];
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end else begin
            // An unread byte being replaced is an overrun unless rd consumes it now.
            if (rxv_q && !rd) ovr_d = 1'b1;
            rdata_d = rx_q;
            rxv_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      rxv_q   <= 1'b0;
      ovr_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      rxv_q   <= rxv_d;
      ovr_q   <= ovr_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign rx_valid = rxv_q;
  assign ovr      = ovr_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// Scoreboard bench for spi_ctrl: expected bytes queued at issue, checked at each completion.
module tb_spi_ctrl;

  localparam int CLK_DIV = 2;

  logic       clk = 1'b0, rst = 1'b1, cmd = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, rx_valid, ovr, sck, mosi, miso, cs_n;

  spi_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata), .busy(busy), .rx_valid(rx_valid), .ovr(ovr),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slave model: mode 0 shifts slv_byte out MSB first, 1 echoes mosi, 2 ties low.
  int         mode = 0;
  logic [7:0] slv_byte = '0;
  logic       tb_clr = 1'b0;
  int         rise_cnt, fall_cnt;
  logic [7:0] mosi_rx;

  always @(posedge sck or posedge tb_clr)
    if (tb_clr) begin rise_cnt <= 0; mosi_rx <= '0; end
    else begin rise_cnt <= rise_cnt + 1; mosi_rx <= {mosi_rx[6:0], mosi}; end

  always @(negedge sck or posedge tb_clr)
    if (tb_clr) fall_cnt <= 0;
    else        fall_cnt <= fall_cnt + 1;

  assign miso = (mode == 1) ? mosi :
                (mode == 0 && fall_cnt < 8) ? slv_byte[3'(7 - fall_cnt)] : 1'b0;

  typedef struct { logic [7:0] rx; logic [7:0] tx; } exp_t;
  exp_t exp_q[$];

  // Monitor: a busy fall not caused by reset is a completed byte.
  logic rst_e, busy_p = 1'b0;
  int   bcnt = 0;
  always @(posedge clk) begin
    exp_t e;
    rst_e = rst;
    #1;
    if (busy) bcnt++;
    else if (busy_p && !rst_e) begin
      if (exp_q.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e.rx);
        check("mosi_bits", mosi_rx, e.tx);
        check("sck_rises", rise_cnt, 8);
        check("busy_cycles", bcnt, 16 * CLK_DIV);
        check("rx_valid_done", rx_valid, 1);
      end
    end
    if (!busy) bcnt = 0;
    busy_p = busy;
  end

  task automatic clr_counts();
    tb_clr = 1'b1; #1; tb_clr = 1'b0;
  endtask

  task automatic pulse_cmd(input logic [7:0] b);
    @(negedge clk); cmd = 1'b1; wdata = b;
    @(negedge clk); cmd = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input int m, input logic [7:0] sb,
                            input logic push, input logic [7:0] exp_rx);
    exp_t e;
    @(negedge clk);
    clr_counts();
    mode = m; slv_byte = sb;
    if (push) begin e.rx = exp_rx; e.tx = tx; exp_q.push_back(e); end
    wr = 1'b1; wdata = tx;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] lb_exp;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_ovr", ovr, 0);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    rst = 1'b0;

    // 1: select, then 0xA5 out with slave returning 0x3C
    pulse_cmd(8'h01);
    check("t1_cs_n", cs_n, 0);
    start_xfer(8'hA5, 0, 8'h3C, 1'b1, 8'h3C);
    check("t1_busy", busy, 1);
    wait_idle();
    check("t1_rx_valid", rx_valid, 1);
    check("t1_ovr", ovr, 0);
    pulse_rd();
    check("t1_rd_clear", rx_valid, 0);

    // 2: second wr while busy is dropped and flags overrun
    start_xfer(8'h11, 0, 8'h5E, 1'b1, 8'h5E);
    repeat (3) @(negedge clk);
    wr = 1'b1; wdata = 8'h22;
    @(negedge clk); wr = 1'b0;
    check("t2_ovr_set", ovr, 1);
    check("t2_busy_kept", busy, 1);
    wait_idle();
    pulse_cmd(8'h03);
    check("t2_ovr_clr", ovr, 0);
    check("t2_cs_n", cs_n, 0);
    pulse_rd();

    // 3: cmd and wr together: cmd wins, wr dropped
    @(negedge clk); clr_counts();
    cmd = 1'b1; wr = 1'b1; wdata = 8'h00;
    @(negedge clk); cmd = 1'b0; wr = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_cs_n", cs_n, 1);
    check("t3_no_sck", rise_cnt, 0);
    check("t3_ovr", ovr, 1);
    check("t3_busy", busy, 0);
    pulse_cmd(8'h03);
    check("t3_ovr_clr", ovr, 0);

    // 4: back-to-back without rd, echo slave
    start_xfer(8'hFF, 1, 8'h00, 1'b1, 8'hFF);
    wait_idle();
    check("t4_ovr_first", ovr, 0);
    start_xfer(8'h00, 1, 8'h00, 1'b1, 8'h00);
    wait_idle();
    check("t4_rdata", rdata, 8'h00);
    check("t4_ovr", ovr, 1);
    pulse_rd();
    check("t4_rd_clear", rx_valid, 0);

    // 5: reset in the middle of a byte
    start_xfer(8'h96, 0, 8'hC7, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    check("t5_mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_sck", sck, 0);
    check("t5_cs_n", cs_n, 1);
    check("t5_busy", busy, 0);
    check("t5_rdata", rdata, 0);
    check("t5_ovr", ovr, 0);
    rst = 1'b0;
    pulse_cmd(8'h01);
    start_xfer(8'h5A, 0, 8'hA7, 1'b1, 8'hA7);
    wait_idle();
    check("t5_rx_valid", rx_valid, 1);
    pulse_rd();

    // 6: miso tied low; loopback build returns the transmitted byte
`ifdef SPI_CTRL_LOOPBACK_EN
    lb_exp = 8'hC3;
`else
    lb_exp = 8'h00;
`endif
    start_xfer(8'hC3, 2, 8'h00, 1'b1, lb_exp);
    wait_idle();
    check("t6_rdata", rdata, lb_exp);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
